cpu_term_gen: RTL and testbench

Slave-side 68030 bus-cycle responder for SDMAC register accesses. It is the counterpart of the DMA master state machine: the master samples DSACK/STERM_ from a target, and this block generates them. It synchronises the CPU strobes, issues one-cycle register read and write strobes, inserts programmable wait states, drives the termination signals and releases them cleanly.

---
 rtl/cpu_term_gen.sv | 156 +++++++++++++++
 tb/tb_cpu_term_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_term_gen.sv
// 68030 slave-side bus responder for SDMAC register accesses: synchronises AS_/DS_,
// issues one-cycle register strobes, inserts wait states and terminates via DSACK_ or STERM_.
module cpu_term_gen #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned USE_STERM   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AS_,
    input  logic        DS_,
    input  logic        R_W,
    input  logic        CS,
    input  logic [4:0]  A,
    input  logic [31:0] REG_DIN,
    output logic [4:0]  REG_ADDR,
    output logic        RD_STB,
    output logic        WR_STB,
    output logic [31:0] DOUT,
    output logic        DBOE_,
    output logic        DSACK_,
    output logic        DSACK_OE,
    output logic        STERM_
);

    typedef enum logic [2:0] {
        StIdle,
        StDecode,
        StIgnore,
        StAccess,
        StWait,
        StTerm,
        StRelease,
        StHold
    } state_e;

    state_e                 state_q;
    state_e                 abort_state;
    logic [SYNC_STAGES-1:0] as_sync_q;
    logic [SYNC_STAGES-1:0] ds_sync_q;
    logic [3:0]             wait_cnt_q;
    logic                   read_q;
    logic                   ass;
    logic                   dss;

    assign ass = as_sync_q[SYNC_STAGES-1];
    assign dss = ds_sync_q[SYNC_STAGES-1];

    // A driven DSACK_ must be released actively before tristating.
    assign abort_state = DSACK_OE ? StRelease : StIdle;

    always_ff @(posedge CLK) begin
        if (RST) begin
            as_sync_q <= '1;
            ds_sync_q <= '1;
        end else begin
            as_sync_q <= {as_sync_q[SYNC_STAGES-2:0], AS_};
            ds_sync_q <= {ds_sync_q[SYNC_STAGES-2:0], DS_};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            read_q     <= 1'b0;
            REG_ADDR   <= 5'd0;
            RD_STB     <= 1'b0;
            WR_STB     <= 1'b0;
            DOUT       <= 32'd0;
            DBOE_      <= 1'b1;
            DSACK_     <= 1'b1;
            DSACK_OE   <= 1'b0;
            STERM_     <= 1'b1;
        end else begin
            RD_STB <= 1'b0;
            WR_STB <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!ass) state_q <= StDecode;
                end
                StDecode: begin
                    REG_ADDR <= A;
                    read_q   <= R_W;
                    if (ass) begin
                        state_q <= abort_state;
                    end else if (!CS) begin
                        state_q <= StIgnore;
                    end else if (R_W) begin
                        state_q <= StAccess;
                        RD_STB  <= 1'b1;
                        DBOE_   <= 1'b0;
                    end else if (!dss) begin
                        state_q <= StAccess;
                        WR_STB  <= 1'b1;
                    end
                end
                StIgnore: begin
                    if (ass) state_q <= StIdle;
                end
                StAccess: begin
                    if (read_q) DOUT <= REG_DIN;
                    wait_cnt_q <= 4'(WAIT_STATES);
                    if (ass) begin
                        state_q <= abort_state;
                        DBOE_   <= 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_q <= StTerm;
                        if (USE_STERM != 0) begin
                            STERM_ <= 1'b0;
                        end else begin
                            DSACK_   <= 1'b0;
                            DSACK_OE <= 1'b1;
                        end
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (ass) begin
                        state_q <= abort_state;
                        DBOE_   <= 1'b1;
                    end else if (wait_cnt_q <= 4'd1) begin
                        state_q <= StTerm;
                        if (USE_STERM != 0) begin
                            STERM_ <= 1'b0;
                        end else begin
                            DSACK_   <= 1'b0;
                            DSACK_OE <= 1'b1;
                        end
                    end
                end
                StTerm: begin
                    if (USE_STERM != 0) begin
                        STERM_  <= 1'b1;
                        DBOE_   <= 1'b1;
                        state_q <= StHold;
                    end else if (ass) begin
                        DSACK_  <= 1'b1;
                        DBOE_   <= 1'b1;
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    DSACK_OE <= 1'b0;
                    state_q  <= StIdle;
                end
                StHold: begin
                    if (ass) state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_term_gen.sv
// Directed bench for cpu_term_gen: a per-cycle read vector table plus hand sequences
// for write, STERM_, ignored, aborted and reset-interrupted cycles on three configurations.
module tb_cpu_term_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        as_n, ds_n, rw, cs;
    logic [4:0]  a;
    logic [31:0] din;

    // Configuration 0: WAIT_STATES = 2, DSACK_ termination
    logic [4:0]  addr0;
    logic        rd0, wr0, dboe0, dsack0, oe0, sterm0;
    logic [31:0] dout0;
    // Configuration 1: WAIT_STATES = 0, STERM_ termination
    logic [4:0]  addr1;
    logic        rd1, wr1, dboe1, dsack1, oe1, sterm1;
    logic [31:0] dout1;
    // Configuration 2: WAIT_STATES = 8, DSACK_ termination
    logic [4:0]  addr2;
    logic        rd2, wr2, dboe2, dsack2, oe2, sterm2;
    logic [31:0] dout2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_term_gen #(.WAIT_STATES(2), .USE_STERM(0), .SYNC_STAGES(2)) dut (
        .CLK(clk), .RST(rst), .AS_(as_n), .DS_(ds_n), .R_W(rw), .CS(cs), .A(a),
        .REG_DIN(din), .REG_ADDR(addr0), .RD_STB(rd0), .WR_STB(wr0), .DOUT(dout0),
        .DBOE_(dboe0), .DSACK_(dsack0), .DSACK_OE(oe0), .STERM_(sterm0)
    );

    cpu_term_gen #(.WAIT_STATES(0), .USE_STERM(1), .SYNC_STAGES(2)) dut_st (
        .CLK(clk), .RST(rst), .AS_(as_n), .DS_(ds_n), .R_W(rw), .CS(cs), .A(a),
        .REG_DIN(din), .REG_ADDR(addr1), .RD_STB(rd1), .WR_STB(wr1), .DOUT(dout1),
        .DBOE_(dboe1), .DSACK_(dsack1), .DSACK_OE(oe1), .STERM_(sterm1)
    );

    cpu_term_gen #(.WAIT_STATES(8), .USE_STERM(0), .SYNC_STAGES(2)) dut_w8 (
        .CLK(clk), .RST(rst), .AS_(as_n), .DS_(ds_n), .R_W(rw), .CS(cs), .A(a),
        .REG_DIN(din), .REG_ADDR(addr2), .RD_STB(rd2), .WR_STB(wr2), .DOUT(dout2),
        .DBOE_(dboe2), .DSACK_(dsack2), .DSACK_OE(oe2), .STERM_(sterm2)
    );

    logic [42:0] obs0, obs1, obs2;
    assign obs0 = {rd0, wr0, dout0, addr0, dboe0, dsack0, oe0, sterm0};
    assign obs1 = {rd1, wr1, dout1, addr1, dboe1, dsack1, oe1, sterm1};
    assign obs2 = {rd2, wr2, dout2, addr2, dboe2, dsack2, oe2, sterm2};

    typedef struct {
        logic        as_n;
        logic        ds_n;
        logic        rw;
        logic        cs;
        logic [4:0]  a;
        logic [31:0] din;
        logic [42:0] exp;
    } vec_t;

    function automatic logic [42:0] ob(input logic r, input logic w, input logic [31:0] d,
                                       input logic [4:0] ad, input logic be, input logic ds,
                                       input logic oe, input logic st);
        return {r, w, d, ad, be, ds, oe, st};
    endfunction

    function automatic vec_t mkv(input logic as_i, input logic ds_i, input logic [4:0] a_i,
                                 input logic [31:0] din_i, input logic [42:0] exp_i);
        vec_t v;
        v.as_n = as_i;
        v.ds_n = ds_i;
        v.rw   = 1'b1;
        v.cs   = 1'b1;
        v.a    = a_i;
        v.din  = din_i;
        v.exp  = exp_i;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        as_n = 1'b1;
        ds_n = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] BG = 32'h0BADF00D;

    vec_t vecs [13];
    logic [42:0] rst_vec;

    initial begin
        int rd_cnt, wr_cnt, wr_idx, ds_idx, rd_idx, st_cnt, st_idx, be_cnt, act0, act1, act2;
        logic oe_seen, be_low, be7, be8;

        rst_vec = ob(1'b0, 1'b0, 32'h0, 5'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 13; i++) begin
            logic [42:0] e;
            if (i < 3)       e = ob(0, 0, 32'h0, 5'h00, 1, 1, 0, 1);
            else if (i == 3) e = ob(1, 0, 32'h0, 5'h04, 0, 1, 0, 1);
            else if (i < 6)  e = ob(0, 0, DB,    5'h04, 0, 1, 0, 1);
            else if (i < 10) e = ob(0, 0, DB,    5'h04, 0, 0, 1, 1);
            else if (i == 10) e = ob(0, 0, DB,   5'h04, 1, 1, 1, 1);
            else             e = ob(0, 0, DB,    5'h04, 1, 1, 0, 1);
            vecs[i] = mkv((i >= 8), (i >= 8), (i == 3) ? 5'h04 : 5'h1B,
                          (i == 4) ? DB : BG, e);
        end

        rst = 1'b1; as_n = 1'b1; ds_n = 1'b1; rw = 1'b1; cs = 1'b0; a = '0; din = '0;
        repeat (3) tick();
        check("reset_cfg0", obs0, rst_vec);
        check("reset_cfg1", obs1, rst_vec);
        check("reset_cfg2", obs2, rst_vec);
        rst = 1'b0;
        tick();

        // Read, WAIT_STATES = 2: one row per clock edge
        for (int i = 0; i < 13; i++) begin
            as_n = vecs[i].as_n; ds_n = vecs[i].ds_n; rw = vecs[i].rw;
            cs = vecs[i].cs; a = vecs[i].a; din = vecs[i].din;
            tick();
            check($sformatf("read_vec%0d", i), obs0, vecs[i].exp);
        end
        idle(3);

        // CS = 0: every configuration must stay silent
        act0 = 0; act1 = 0; act2 = 0;
        cs = 1'b0; rw = 1'b1; a = 5'h07;
        for (int i = 0; i < 12; i++) begin
            as_n = (i >= 6); ds_n = (i >= 6);
            tick();
            if (rd0 || wr0 || oe0 || !dboe0 || !dsack0) act0++;
            if (rd1 || wr1 || oe1 || !dboe1 || !sterm1) act1++;
            if (rd2 || wr2 || oe2 || !dboe2 || !dsack2) act2++;
        end
        check("ignore_cfg0_active", act0, 0);
        check("ignore_cfg1_active", act1, 0);
        check("ignore_cfg2_active", act2, 0);

        // Write with DS_ lagging AS_ by 3 cycles
        rd_cnt = 0; wr_cnt = 0; wr_idx = -1; ds_idx = -1; be_low = 1'b0;
        cs = 1'b1; rw = 1'b0; a = 5'h09; as_n = 1'b0; ds_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) ds_n = 1'b0;
            if (i == 11) begin as_n = 1'b1; ds_n = 1'b1; end
            tick();
            if (wr0) begin wr_cnt++; wr_idx = i; end
            if (rd0) rd_cnt++;
            if (!dboe0) be_low = 1'b1;
            if (!dsack0 && ds_idx < 0) ds_idx = i;
        end
        idle(3);
        check("write_wr_count", wr_cnt, 1);
        check("write_wr_cycle", wr_idx, 5);
        check("write_rd_count", rd_cnt, 0);
        check("write_dboe_low", be_low, 0);
        check("write_dsack_cycle", ds_idx, 5 + 1 + 2);
        check("write_reg_addr", addr0, 5'h09);
        check("write_released", {oe0, dsack0}, 2'b01);

        // STERM_ with WAIT_STATES = 0, AS_ held low well past termination
        rd_cnt = 0; rd_idx = -1; st_cnt = 0; st_idx = -1; be_cnt = 0; oe_seen = 1'b0;
        cs = 1'b1; rw = 1'b1; a = 5'h02; din = 32'h55AA55AA; as_n = 1'b0; ds_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin as_n = 1'b1; ds_n = 1'b1; end
            tick();
            if (rd1) begin rd_cnt++; rd_idx = i; end
            if (!sterm1) begin st_cnt++; st_idx = i; end
            if (!dboe1) be_cnt++;
            if (oe1) oe_seen = 1'b1;
        end
        idle(3);
        check("sterm_rd_count", rd_cnt, 1);
        check("sterm_rd_cycle", rd_idx, 3);
        check("sterm_low_cycles", st_cnt, 1);
        check("sterm_cycle", st_idx, 4);
        check("sterm_dboe_cycles", be_cnt, 2);
        check("sterm_dsack_oe", oe_seen, 0);
        check("sterm_dout", dout1, 32'h55AA55AA);

        // WAIT_STATES = 8: AS_ negated mid-WAIT
        rd_cnt = 0; oe_seen = 1'b0; ds_idx = -1; be7 = 1'b1; be8 = 1'b0;
        cs = 1'b1; rw = 1'b1; a = 5'h03; din = 32'hCAFEF00D; as_n = 1'b0; ds_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin as_n = 1'b1; ds_n = 1'b1; end
            tick();
            if (rd2) rd_cnt++;
            if (oe2) oe_seen = 1'b1;
            if (!dsack2) ds_idx = i;
            if (i == 7) be7 = dboe2;
            if (i == 8) be8 = dboe2;
        end
        check("abort_rd_count", rd_cnt, 1);
        check("abort_no_dsack", ds_idx, -1);
        check("abort_no_dsack_oe", oe_seen, 0);
        check("abort_dboe_before", be7, 0);
        check("abort_dboe_after", be8, 1);

        // Follow-up cycle proves the aborted block is back in IDLE
        rd_idx = -1; ds_idx = -1;
        as_n = 1'b0; ds_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 14) begin as_n = 1'b1; ds_n = 1'b1; end
            tick();
            if (rd2 && rd_idx < 0) rd_idx = i;
            if (!dsack2 && ds_idx < 0) ds_idx = i;
        end
        idle(4);
        check("wait8_rd_cycle", rd_idx, 3);
        check("wait8_dsack_cycle", ds_idx, 4 + 8);

        // RST while in TERM
        cs = 1'b1; rw = 1'b1; a = 5'h1F; din = 32'h12345678; as_n = 1'b0; ds_n = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("rst_pre_term", {dsack0, oe0, dboe0}, 3'b010);
        rst = 1'b1; as_n = 1'b1; ds_n = 1'b1;
        tick();
        check("rst_in_term_cfg0", obs0, rst_vec);
        check("rst_in_hold_cfg1", obs1, rst_vec);
        rst = 1'b0;
        oe_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (oe0 || !dsack0) oe_seen = 1'b1;
        end
        check("rst_no_release", oe_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
